// File: rtl/smm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// smm_pkg : shared lane geometry and state encodings for the Strassen datapath
// rev 1.0
// ---------------------------------------------------------------------------
package smm_pkg;

   localparam int BLOCKSIZE = 32;
   localparam int NLANES    = 4;

   localparam logic [0:0] c_acc_idle  = 1'b0;
   localparam logic [0:0] c_acc_run   = 1'b1;
   localparam logic [0:0] c_out_empty = 1'b0;
   localparam logic [0:0] c_out_full  = 1'b1;

   // Low bit of lane j in a packed tile; lane 0 sits in the LSBs.
   function automatic int lane_lo(input int lane, input int width);
      return lane * width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/smm_lane_add.sv
`default_nettype none
// ---------------------------------------------------------------------------
// smm_lane_add : lane-wise modular adder, no carry between lanes
// rev 1.0
// ---------------------------------------------------------------------------
module smm_lane_add
   import smm_pkg::*;
#(
   parameter int LANEW = BLOCKSIZE,
   parameter int LANES = NLANES
) (
   input  logic [LANES*LANEW-1:0] a,
   input  logic [LANES*LANEW-1:0] b,
   output logic [LANES*LANEW-1:0] sum
);

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign sum[lane_lo(j, LANEW) +: LANEW] =
         a[lane_lo(j, LANEW) +: LANEW] + b[lane_lo(j, LANEW) +: LANEW];
   end

endmodule
`default_nettype wire

// File: rtl/smm_tile_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// smm_tile_accum : sums KTILES partial-product tiles into one output tile
// rev 1.0
// ---------------------------------------------------------------------------
module smm_tile_accum #(
   parameter int BLOCKSIZE = smm_pkg::BLOCKSIZE,
   parameter int DATAWIDTH = smm_pkg::NLANES * BLOCKSIZE,
   parameter int KTILES    = 4,
   parameter int CNTW      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] in_data,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] out_data,
   output logic [CNTW-1:0]      out_count
);
   import smm_pkg::*;

   localparam int              c_kw     = (KTILES > 1) ? $clog2(KTILES) : 1;
   localparam logic [c_kw-1:0] c_k_last = c_kw'(KTILES - 1);
   localparam logic [c_kw-1:0] c_k_one  = c_kw'(1);

   logic [DATAWIDTH-1:0] r_acc;
   logic [DATAWIDTH-1:0] r_out_data;
   logic [DATAWIDTH-1:0] w_acc_base;
   logic [DATAWIDTH-1:0] w_sum;
   logic [c_kw-1:0]      r_k_cnt;
   logic [CNTW-1:0]      r_out_count;
   logic [0:0]           w_acc_state;
   logic [0:0]           r_out_state;
   logic [0:0]           w_out_state_nxt;
   logic                 w_last;
   logic                 w_accept;
   logic                 w_done;
   logic                 w_out_hs;

   // An idle accumulator loads the incoming word rather than adding to stale data.
   assign w_acc_state = (r_k_cnt == '0) ? c_acc_idle : c_acc_run;
   assign w_acc_base  = (w_acc_state == c_acc_idle) ? '0 : r_acc;

   smm_lane_add #(
      .LANEW (BLOCKSIZE),
      .LANES (DATAWIDTH / BLOCKSIZE)
   ) u_lane_add (
      .a   (w_acc_base),
      .b   (in_data),
      .sum (w_sum)
   );

   assign w_last   = (r_k_cnt == c_k_last);
   assign in_ready = !flush && !(w_last && out_valid && !out_ready);
   assign w_accept = in_valid && in_ready;
   assign w_done   = w_accept && w_last;
   assign w_out_hs = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc   <= '0;
         r_k_cnt <= '0;
      end else if (flush) begin
         r_acc   <= '0;
         r_k_cnt <= '0;
      end else if (w_accept) begin
         r_acc   <= w_last ? '0 : w_sum;
         r_k_cnt <= w_last ? '0 : r_k_cnt + c_k_one;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_count <= '0;
      end else if (w_done) begin
         r_out_data  <= w_sum;
         r_out_count <= r_out_count + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_out_state <= c_out_empty;
      else     r_out_state <= w_out_state_nxt;
   end

   // A completion in the handshake cycle keeps the register full: no bubble.
   always_comb begin
      w_out_state_nxt = r_out_state;
      if (w_done)        w_out_state_nxt = c_out_full;
      else if (w_out_hs) w_out_state_nxt = c_out_empty;
   end

   always_comb begin
      out_valid = (r_out_state == c_out_full);
   end

   assign out_data  = r_out_data;
   assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_smm_tile_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_smm_tile_accum : directed and randomized bench for smm_tile_accum
// rev 1.0
// ---------------------------------------------------------------------------
module tb_smm_tile_accum;

   localparam int DW = 128;
   localparam int KT = 4;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   smm_tile_accum #(
      .BLOCKSIZE (32),
      .DATAWIDTH (DW),
      .KTILES    (KT),
      .CNTW      (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count)
   );

   // Reference: words of the open tile, plus the held output register.
   logic [DW-1:0] m_q[$];
   bit            m_ov;
   logic [DW-1:0] m_od;
   logic [CW-1:0] m_cnt;
   bit            chk_en = 1'b0;

   function automatic logic [DW-1:0] pack(input logic [31:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [DW-1:0] tile_sum();
      logic [DW-1:0] r = '0;
      for (int l = 0; l < 4; l++) begin
         logic [31:0] s = 32'd0;
         foreach (m_q[i]) begin
            logic [DW-1:0] w = m_q[i];
            s = s + w[32*l +: 32];
         end
         r[32*l +: 32] = s;
      end
      return r;
   endfunction

   function automatic bit exp_ready();
      return !flush && !((m_q.size() == KT-1) && m_ov && !out_ready);
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ov  = 1'b0;
      m_od  = '0;
      m_cnt = '0;
   endtask

   task automatic model_update();
      bit acc;
      bit done;
      acc  = in_valid && exp_ready();
      done = 1'b0;
      if (flush) begin
         m_q.delete();
      end else if (acc) begin
         m_q.push_back(in_data);
         if (m_q.size() == KT) begin
            m_od  = tile_sum();
            m_ov  = 1'b1;
            m_cnt = m_cnt + 1'b1;
            m_q.delete();
            done  = 1'b1;
         end
      end
      if (!done && out_ready) m_ov = 1'b0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", in_ready, exp_ready());
         chk("out_valid", out_valid, m_ov);
         if (m_ov) chk("out_data", out_data, m_od);
         chk("out_count", out_count, m_cnt);
      end
   end

   // One cycle: drive inputs, let the compare run at negedge, advance model, pass posedge.
   task automatic cyc(input bit v, input logic [DW-1:0] d, input bit ordy, input bit fl);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      #1;
      model_update();
      @(posedge clk);
      #1;
   endtask

   int pulses;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, '0);
      chk("rst_out_count", out_count, '0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      // basic sum
      repeat (4) cyc(1'b1, pack(1, 2, 3, 4), 1'b1, 1'b0);
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_data", out_data, pack(4, 8, 12, 16));
      chk("t1_count", out_count, 1);

      // lane wrap without cross-lane carry
      cyc(1'b1, pack(32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000), 1'b1, 1'b0);
      cyc(1'b1, pack(32'h0000_0002, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000), 1'b1, 1'b0);
      cyc(1'b1, pack(0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000), 1'b1, 1'b0);
      cyc(1'b1, pack(0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000), 1'b1, 1'b0);
      chk("t2_data", out_data, pack(1, 0, 0, 0));

      // back-pressure on the completing beat
      repeat (3) cyc(1'b1, pack(10, 20, 30, 40), 1'b0, 1'b0);
      in_valid = 1'b1; in_data = pack(10, 20, 30, 40); out_ready = 1'b0; flush = 1'b0;
      #1;
      chk("t3_stall_ready", in_ready, 1'b0);
      cyc(1'b1, pack(10, 20, 30, 40), 1'b0, 1'b0);
      chk("t3_held_data", out_data, pack(1, 0, 0, 0));
      cyc(1'b1, pack(10, 20, 30, 40), 1'b1, 1'b0);
      chk("t3_valid", out_valid, 1'b1);
      chk("t3_data", out_data, pack(40, 80, 120, 160));

      // back-to-back tiles
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, pack(i, 2*i, 3*i, 4*i), 1'b1, 1'b0);
         if (out_valid) pulses++;
      end
      chk("t4_pulses", pulses, 3);
      chk("t4_count", out_count, 6);

      // flush discards a partial tile
      repeat (2) cyc(1'b1, pack(5, 5, 5, 5), 1'b1, 1'b0);
      in_valid = 1'b1; in_data = pack(9, 9, 9, 9); out_ready = 1'b1; flush = 1'b1;
      #1;
      chk("t5_flush_ready", in_ready, 1'b0);
      cyc(1'b1, pack(9, 9, 9, 9), 1'b1, 1'b1);
      repeat (4) cyc(1'b1, pack(1, 1, 1, 1), 1'b0, 1'b0);
      chk("t5_data", out_data, pack(4, 4, 4, 4));

      // asynchronous reset mid-tile with a held output
      repeat (2) cyc(1'b1, pack(3, 3, 3, 3), 1'b0, 1'b0);
      chk("t6_pre_valid", out_valid, 1'b1);
      chk_en = 1'b0;
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", out_valid, 1'b0);
      chk("t6_rst_count", out_count, '0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      repeat (4) cyc(1'b1, pack(2, 0, 0, 7), 1'b1, 1'b0);
      chk("t6_data", out_data, pack(8, 0, 0, 28));

      // randomized traffic against the reference
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 3) != 0,
             {$urandom, $urandom, $urandom, $urandom},
             $urandom_range(0, 9) < 6,
             $urandom_range(0, 99) < 3);
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
